// File: rtl/cpu_pkg.sv
// Shared types and encodings for the simple RISC control unit: FSM states,
// instruction classes, opcode fields and datapath command encodings.
package cpu_pkg;

  typedef enum logic [4:0] {
    S_RST, S_IF1, S_IF2, S_UPDATE_PC, S_DECODE, S_WRITE_IMM, S_GET_A, S_GET_B,
    S_EXEC, S_WRITE_REG, S_ADDR, S_LOAD_ADDR, S_MEM_RD, S_WRITE_MDATA,
    S_MOVE, S_MEM_WR, S_HALT
  } state_e;

  typedef enum logic [2:0] {
    C_MOV_IMM, C_MOV_REG, C_ALU, C_CMP, C_MVN, C_LDR, C_STR, C_HALT
  } instr_class_e;

  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_PC    = 2'b01;
  localparam logic [1:0] VSEL_IMM8  = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational instruction decoder: splits IR fields, sign-extends the
// immediates and classifies the instruction; unknown encodings classify as HALT.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [15:0]  ir,
  output logic [1:0]   op,
  output logic [2:0]   rn,
  output logic [2:0]   rd,
  output logic [1:0]   sh,
  output logic [2:0]   rm,
  output logic [15:0]  sximm5,
  output logic [15:0]  sximm8,
  output instr_class_e iclass
);

  logic [2:0] opcode;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];
  assign sximm5 = {{11{ir[4]}}, ir[4:0]};
  assign sximm8 = {{8{ir[7]}}, ir[7:0]};

  always_comb begin
    iclass = C_HALT;
    unique case (opcode)
      OPC_MOV: begin
        if (op == OP_MOV_IMM)      iclass = C_MOV_IMM;
        else if (op == OP_MOV_REG) iclass = C_MOV_REG;
      end
      OPC_ALU: begin
        unique case (op)
          OP_ADD, OP_AND: iclass = C_ALU;
          OP_CMP:         iclass = C_CMP;
          OP_MVN:         iclass = C_MVN;
          default:        iclass = C_HALT;
        endcase
      end
      OPC_LDR:  if (op == 2'b00) iclass = C_LDR;
      OPC_STR:  if (op == 2'b00) iclass = C_STR;
      default:  iclass = C_HALT;
    endcase
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// Moore control unit for the simple RISC datapath: holds the instruction
// register and sequences fetch, decode and execute of each instruction.
module cpu_control_fsm
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] read_data,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic [1:0]  vsel,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm5,
  output logic [15:0] sximm8,
  output logic        load_pc,
  output logic        reset_pc,
  output logic        load_addr,
  output logic        addr_sel,
  output logic [1:0]  mem_cmd,
  output logic        halted
);

  state_e       state_q, state_d;
  logic [15:0]  ir_q, ir_d;
  logic [1:0]   op;
  logic [2:0]   rn, rd, rm;
  logic [1:0]   sh;
  instr_class_e iclass;

  instr_decoder u_decoder (
    .ir     (ir_q),
    .op     (op),
    .rn     (rn),
    .rd     (rd),
    .sh     (sh),
    .rm     (rm),
    .sximm5 (sximm5),
    .sximm8 (sximm8),
    .iclass (iclass)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RST;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Outputs depend only on state_q and ir_q, so read_data never reaches a control pin.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    readnum   = 3'd0;
    writenum  = 3'd0;
    write     = 1'b0;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    vsel      = VSEL_C;
    asel      = 1'b0;
    bsel      = 1'b0;
    shift     = 2'b00;
    ALUop     = ALU_ADD;
    load_pc   = 1'b0;
    reset_pc  = 1'b0;
    load_addr = 1'b0;
    addr_sel  = 1'b0;
    mem_cmd   = MEM_NONE;
    halted    = 1'b0;

    unique case (state_q)
      S_RST: begin
        reset_pc = 1'b1;
        load_pc  = 1'b1;
        state_d  = S_IF1;
      end
      S_IF1: begin
        addr_sel = 1'b1;
        mem_cmd  = MEM_READ;
        state_d  = S_IF2;
      end
      S_IF2: begin
        addr_sel = 1'b1;
        mem_cmd  = MEM_READ;
        ir_d     = read_data;
        state_d  = S_UPDATE_PC;
      end
      S_UPDATE_PC: begin
        load_pc = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        unique case (iclass)
          C_MOV_IMM:                    state_d = S_WRITE_IMM;
          C_MOV_REG, C_MVN:             state_d = S_GET_B;
          C_ALU, C_CMP, C_LDR, C_STR:   state_d = S_GET_A;
          default:                      state_d = S_HALT;
        endcase
      end
      S_WRITE_IMM: begin
        vsel     = VSEL_IMM8;
        writenum = rn;
        write    = 1'b1;
        state_d  = S_IF1;
      end
      S_GET_A: begin
        readnum = rn;
        loada   = 1'b1;
        state_d = (iclass == C_LDR || iclass == C_STR) ? S_ADDR : S_GET_B;
      end
      // STR reuses GET_B to fetch the store data from Rd rather than Rm.
      S_GET_B: begin
        readnum = (iclass == C_STR) ? rd : rm;
        loadb   = 1'b1;
        state_d = (iclass == C_STR) ? S_MOVE : S_EXEC;
      end
      S_EXEC: begin
        shift = sh;
        loadc = 1'b1;
        unique case (iclass)
          C_MOV_REG: begin
            asel  = 1'b1;
            ALUop = ALU_ADD;
          end
          C_MVN: ALUop = ALU_MVN;
          C_CMP: begin
            ALUop = ALU_SUB;
            loads = 1'b1;
            loadc = 1'b0;
          end
          default: ALUop = op;
        endcase
        state_d = (iclass == C_CMP) ? S_IF1 : S_WRITE_REG;
      end
      S_WRITE_REG: begin
        vsel     = VSEL_C;
        writenum = rd;
        write    = 1'b1;
        state_d  = S_IF1;
      end
      S_ADDR: begin
        bsel    = 1'b1;
        loadc   = 1'b1;
        state_d = S_LOAD_ADDR;
      end
      S_LOAD_ADDR: begin
        load_addr = 1'b1;
        state_d   = (iclass == C_STR) ? S_GET_B : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_cmd = MEM_READ;
        state_d = S_WRITE_MDATA;
      end
      S_WRITE_MDATA: begin
        mem_cmd  = MEM_READ;
        vsel     = VSEL_MDATA;
        writenum = rd;
        write    = 1'b1;
        state_d  = S_IF1;
      end
      S_MOVE: begin
        asel    = 1'b1;
        loadc   = 1'b1;
        state_d = S_MEM_WR;
      end
      S_MEM_WR: begin
        mem_cmd = MEM_WRITE;
        state_d = S_IF1;
      end
      S_HALT: begin
        halted  = 1'b1;
        state_d = S_HALT;
      end
      default: state_d = S_RST;
    endcase
  end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench for cpu_control_fsm: walks each instruction class state by
// state and compares the full control word against hand-computed values.
module tb_cpu_control_fsm;

  typedef struct packed {
    logic       write, loada, loadb, loadc, loads, asel, bsel;
    logic       load_pc, reset_pc, load_addr, addr_sel, halted;
    logic [1:0] mem_cmd, vsel, shift, aluop;
    logic [2:0] readnum, writenum;
  } ctrl_t;

  logic        clk;
  logic        reset;
  logic [15:0] read_data;
  logic [2:0]  readnum, writenum;
  logic        write, loada, loadb, loadc, loads, asel, bsel;
  logic [1:0]  vsel, shift, ALUop, mem_cmd;
  logic [15:0] sximm5, sximm8;
  logic        load_pc, reset_pc, load_addr, addr_sel, halted;

  ctrl_t obs;
  ctrl_t e;
  int    checks   = 0;
  int    failures = 0;

  cpu_control_fsm dut (
    .clk       (clk),
    .reset     (reset),
    .read_data (read_data),
    .readnum   (readnum),
    .writenum  (writenum),
    .write     (write),
    .loada     (loada),
    .loadb     (loadb),
    .loadc     (loadc),
    .loads     (loads),
    .vsel      (vsel),
    .asel      (asel),
    .bsel      (bsel),
    .shift     (shift),
    .ALUop     (ALUop),
    .sximm5    (sximm5),
    .sximm8    (sximm8),
    .load_pc   (load_pc),
    .reset_pc  (reset_pc),
    .load_addr (load_addr),
    .addr_sel  (addr_sel),
    .mem_cmd   (mem_cmd),
    .halted    (halted)
  );

  assign obs = ctrl_t'({write, loada, loadb, loadc, loads, asel, bsel,
                        load_pc, reset_pc, load_addr, addr_sel, halted,
                        mem_cmd, vsel, shift, ALUop, readnum, writenum});

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_ctrl(input string tag, input ctrl_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%07h expected=%07h", tag, 26'(obs), 26'(exp));
    end
  endtask

  task automatic check16(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%04h expected=%04h", tag, got, exp);
    end
  endtask

  function automatic ctrl_t w_rst();
    ctrl_t c = '0;
    c.reset_pc = 1'b1;
    c.load_pc  = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t w_fetch();
    ctrl_t c = '0;
    c.addr_sel = 1'b1;
    c.mem_cmd  = 2'b01;
    return c;
  endfunction

  function automatic ctrl_t w_upc();
    ctrl_t c = '0;
    c.load_pc = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t w_halt();
    ctrl_t c = '0;
    c.halted = 1'b1;
    return c;
  endfunction

  // Fetch leg shared by every instruction: IF1 sampled already, then IF2, UPDATE_PC, DECODE.
  task automatic fetch_decode(input string name);
    step(); check_ctrl({name, "_if2"}, w_fetch());
    step(); check_ctrl({name, "_upc"}, w_upc());
    step(); check_ctrl({name, "_decode"}, '0);
  endtask

  initial begin
    reset     = 1'b1;
    read_data = 16'h0000;
    repeat (2) @(negedge clk);
    check_ctrl("reset_state", w_rst());
    check16("reset_sximm8", sximm8, 16'h0000);

    // MOV R0,#-3
    read_data = 16'hD0FD;
    reset     = 1'b0;
    step(); check_ctrl("movi_if1", w_fetch());
    fetch_decode("movi");
    check16("movi_sximm8", sximm8, 16'hFFFD);
    step();
    e = '0; e.vsel = 2'b10; e.writenum = 3'd0; e.write = 1'b1;
    check_ctrl("movi_write_imm", e);
    step(); check_ctrl("movi_next_if1_5cyc", w_fetch());

    // ADD R2,R1,R0,LSL#1
    read_data = 16'hA148;
    fetch_decode("add");
    step(); e = '0; e.readnum = 3'd1; e.loada = 1'b1; check_ctrl("add_get_a", e);
    step(); e = '0; e.readnum = 3'd0; e.loadb = 1'b1; check_ctrl("add_get_b", e);
    step(); e = '0; e.shift = 2'b01; e.aluop = 2'b00; e.loadc = 1'b1; check_ctrl("add_exec", e);
    step(); e = '0; e.writenum = 3'd2; e.vsel = 2'b00; e.write = 1'b1; check_ctrl("add_write_reg", e);
    step(); check_ctrl("add_next_if1_8cyc", w_fetch());

    // Same ADD, interrupted by reset in EXEC
    fetch_decode("add2");
    step(); step(); step();
    e = '0; e.shift = 2'b01; e.loadc = 1'b1; check_ctrl("add2_exec", e);
    check16("add2_sximm8", sximm8, 16'h0048);
    reset = 1'b1;
    #1;
    check_ctrl("reset_mid_exec", w_rst());
    check16("reset_mid_exec_sximm8", sximm8, 16'h0000);
    check16("reset_mid_exec_sximm5", sximm5, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    step(); check_ctrl("after_reset_if1", w_fetch());

    // CMP R1,R0
    read_data = 16'hA900;
    fetch_decode("cmp");
    step(); e = '0; e.readnum = 3'd1; e.loada = 1'b1; check_ctrl("cmp_get_a", e);
    step(); e = '0; e.readnum = 3'd0; e.loadb = 1'b1; check_ctrl("cmp_get_b", e);
    step(); e = '0; e.aluop = 2'b01; e.loads = 1'b1; check_ctrl("cmp_exec", e);
    step(); check_ctrl("cmp_next_if1_7cyc", w_fetch());

    // LDR R3,[R1,#-1]
    read_data = 16'h617F;
    fetch_decode("ldr");
    check16("ldr_sximm5", sximm5, 16'hFFFF);
    step(); e = '0; e.readnum = 3'd1; e.loada = 1'b1; check_ctrl("ldr_get_a", e);
    step(); e = '0; e.bsel = 1'b1; e.loadc = 1'b1; check_ctrl("ldr_addr", e);
    step(); e = '0; e.load_addr = 1'b1; check_ctrl("ldr_load_addr", e);
    step(); e = '0; e.mem_cmd = 2'b01; check_ctrl("ldr_mem_rd", e);
    step(); e = '0; e.mem_cmd = 2'b01; e.vsel = 2'b11; e.writenum = 3'd3; e.write = 1'b1;
    check_ctrl("ldr_write_mdata", e);
    step(); check_ctrl("ldr_next_if1_9cyc", w_fetch());

    // STR R2,[R1,#3]
    read_data = 16'h8143;
    fetch_decode("str");
    check16("str_sximm5", sximm5, 16'h0003);
    step(); e = '0; e.readnum = 3'd1; e.loada = 1'b1; check_ctrl("str_get_a", e);
    step(); e = '0; e.bsel = 1'b1; e.loadc = 1'b1; check_ctrl("str_addr", e);
    step(); e = '0; e.load_addr = 1'b1; check_ctrl("str_load_addr", e);
    step(); e = '0; e.readnum = 3'd2; e.loadb = 1'b1; check_ctrl("str_get_b", e);
    step(); e = '0; e.asel = 1'b1; e.loadc = 1'b1; check_ctrl("str_move", e);
    step(); e = '0; e.mem_cmd = 2'b10; check_ctrl("str_mem_wr", e);
    step(); check_ctrl("str_next_if1_10cyc", w_fetch());

    // MOV R5,R3,LSR
    read_data = 16'hC0B3;
    fetch_decode("movr");
    step(); e = '0; e.readnum = 3'd3; e.loadb = 1'b1; check_ctrl("movr_get_b", e);
    step(); e = '0; e.asel = 1'b1; e.shift = 2'b10; e.loadc = 1'b1; check_ctrl("movr_exec", e);
    step(); e = '0; e.writenum = 3'd5; e.write = 1'b1; check_ctrl("movr_write_reg", e);
    step(); check_ctrl("movr_next_if1_7cyc", w_fetch());

    // HALT, then reset out of it
    read_data = 16'hE000;
    fetch_decode("halt");
    for (int i = 0; i < 20; i++) begin
      step(); check_ctrl("halt_hold", w_halt());
    end
    reset = 1'b1;
    #1;
    check_ctrl("halt_reset", w_rst());
    @(negedge clk);
    reset = 1'b0;
    step(); check_ctrl("halt_reset_if1", w_fetch());

    // Illegal encoding 0x0000 behaves as HALT
    read_data = 16'h0000;
    fetch_decode("illegal");
    for (int i = 0; i < 20; i++) begin
      step(); check_ctrl("illegal_hold", w_halt());
    end
    reset = 1'b1;
    #1;
    check_ctrl("illegal_reset", w_rst());
    @(negedge clk);
    reset = 1'b0;
    step(); check_ctrl("illegal_reset_if1", w_fetch());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_control_fsm.md
# cpu_control_fsm

Control unit that drives the register-file/ALU datapath and the instruction/data memory port of the simple RISC machine. Holds the instruction register, decodes the current instruction and steps a Moore state machine that emits every datapath control word (register selects, load enables, mux selects, ALU op, shift) plus PC and memory commands. It is the producer side of the datapath control interface; the datapath only consumes these signals.

## Interface
- No parameters. Word width 16, register index width 3, both fixed.
- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: asynchronous, active-high; forces state RST and clears IR immediately.
- `read_data` in 16: memory read data, used as the instruction source and as `mdata`.
- `readnum`, `writenum` out 3: register-file read and write indices.
- `write` out 1: register-file write enable.
- `loada`, `loadb`, `loadc`, `loads` out 1: datapath register enables.
- `vsel` out 2: write-back select; 00 = C, 01 = PC, 10 = sximm8, 11 = mdata.
- `asel`, `bsel` out 1: asel = 1 selects zero for A; bsel = 1 selects sximm5 for B.
- `shift` out 2: shifter control.
- `ALUop` out 2: 00 ADD, 01 SUB/CMP, 10 AND, 11 MVN.
- `sximm5`, `sximm8` out 16: sign-extended IR[4:0] and IR[7:0].
- `load_pc`, `reset_pc`, `load_addr`, `addr_sel` out 1: PC/address control; addr_sel = 1 selects PC.
- `mem_cmd` out 2: 00 NONE, 01 READ, 10 WRITE.
- `halted` out 1: high in HALT.

## Operation
- IR fields: [15:13] opcode, [12:11] op, [10:8] Rn, [7:5] Rd, [4:3] sh, [2:0] Rm.
- Supported instructions: MOV Rn,#imm8 (110/10); MOV Rd,Rm,sh (110/00); ADD/CMP/AND/MVN (101/op); LDR Rd,[Rn,#imm5] (011/00); STR Rd,[Rn,#imm5] (100/00); HALT (111). Any other encoding goes to HALT.
- Fetch: RST → IF1 (addr_sel=1, mem_cmd=READ) → IF2 (same, IR ← read_data at the edge) → UPDATE_PC (load_pc=1) → DECODE (no enables).
- MOV imm: WRITE_IMM: vsel=10, writenum=Rn, write=1.
- MOV reg / MVN: GET_B (readnum=Rm, loadb=1) → EXEC (asel=1 for MOV, ALUop=00 for MOV or 11 for MVN, shift=sh, loadc=1) → WRITE_REG (vsel=00, writenum=Rd, write=1).
- ADD/AND: GET_A (readnum=Rn, loada=1) → GET_B → EXEC (asel=0, bsel=0, ALUop=op, loadc=1) → WRITE_REG.
- CMP: GET_A → GET_B → EXEC with loads=1 and loadc=0. No write-back.
- LDR: GET_A → ADDR (asel=0, bsel=1, ALUop=00, shift=00, loadc=1) → LOAD_ADDR (load_addr=1) → MEM_RD (addr_sel=0, mem_cmd=READ) → WRITE_MDATA (addr_sel=0, mem_cmd=READ, vsel=11, writenum=Rd, write=1).
- STR: GET_A → ADDR → LOAD_ADDR → GET_B (readnum=Rd, loadb=1) → MOVE (asel=1, bsel=0, shift=00, ALUop=00, loadc=1) → MEM_WR (addr_sel=0, mem_cmd=WRITE).
- The last state of every instruction returns to IF1. HALT is absorbing; only `reset` exits it.
- Defaults (unless listed for a state): all enables 0, mem_cmd=NONE, addr_sel=0, vsel=00, shift=00, ALUop=00, asel=0, bsel=0, readnum/writenum=0.
- RST outputs: reset_pc=1 and load_pc=1; everything else at defaults. reset_pc is 0 in all other states.

## Timing
- Moore outputs: a function of state and IR only, valid the whole cycle, with no combinational path from `read_data` to any control output.
- Reset asserted at any point, including mid-instruction: outputs switch to RST values in the same cycle, IR=0x0000, halted=0.
- First edge after reset release goes RST → IF1.
- Cycles counted IF1 to next IF1: MOV imm 5; MOV reg/MVN 7; CMP 7; ADD/AND 8; LDR 9; STR 10.
- IR changes only on the IF2→UPDATE_PC edge. sximm5/sximm8 stay stable from UPDATE_PC through the end of the instruction.
- Memory is assumed to be 1-cycle read: read_data for an address issued in cycle n is sampled at the end of cycle n+1.

## Structure
- Shared package `cpu_pkg`: state enum, opcode/op constants, mem_cmd encodings (NONE/READ/WRITE), vsel encodings (C/PC/IMM8/MDATA), ALUop encodings.
- One combinational sub-module, `instr_decoder`: splits IR fields, sign-extends the immediates and classifies the instruction (incl. illegal → HALT). The FSM and IR live in the top module.

## Test plan
- Reset in EXEC of an ADD: same cycle write=0, loadc=0, reset_pc=1, load_pc=1, mem_cmd=00; after release, IF1 follows on the next edge with mem_cmd=01, addr_sel=1.
- 0xD0FD (MOV R0,#-3): sximm8=0xFFFD; WRITE_IMM has vsel=10, writenum=0, write=1; next IF1 occurs 5 cycles after the previous IF1.
- 0xA148 (ADD R2,R1,R0,LSL#1): GET_A readnum=1 loada=1; GET_B readnum=0 loadb=1; EXEC shift=01 ALUop=00 loadc=1 loads=0; WRITE_REG writenum=2 vsel=00 write=1.
- 0xA900 (CMP R1,R0): EXEC has loads=1, loadc=0, ALUop=01; write never asserted; 7 cycles.
- 0x617F (LDR R3,[R1,#-1]): sximm5=0xFFFF; ADDR bsel=1 loadc=1; LOAD_ADDR load_addr=1; MEM_RD addr_sel=0 mem_cmd=01; WRITE_MDATA vsel=11 writenum=3 write=1.
- 0xE000 (HALT), then separately 0x0000 (illegal): halted=1, mem_cmd=00 and all enables 0 for 20 cycles; reset returns to RST with halted=0.
